// File: rtl/cmsdk_ahb_param_decoder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : cmsdk_ahb_param_decoder_if
// Brief   : Bus bundle between a matrix input stage, the decoder and the
//           output stages (address-phase select and data-phase return path).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface cmsdk_ahb_param_decoder_if #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int USER_W    = 32
);
  logic                          HREADYS;
  logic                          sel_dec;
  logic [21:0]                   decode_addr_dec;
  logic [1:0]                    trans_dec;
  logic [NUM_PORTS-1:0]          active_dec_i;
  logic [NUM_PORTS-1:0]          readyout_dec_i;
  logic [2*NUM_PORTS-1:0]        resp_dec_i;
  logic [DATA_W*NUM_PORTS-1:0]   rdata_dec_i;
  logic [USER_W*NUM_PORTS-1:0]   ruser_dec_i;

  logic [NUM_PORTS-1:0]          sel_dec_o;
  logic                          active_dec;
  logic                          HREADYOUTS;
  logic [1:0]                    HRESPS;
  logic [DATA_W-1:0]             HRDATAS;
  logic [USER_W-1:0]             HRUSERS;

  modport master (
    output HREADYS, sel_dec, decode_addr_dec, trans_dec,
           active_dec_i, readyout_dec_i, resp_dec_i, rdata_dec_i, ruser_dec_i,
    input  sel_dec_o, active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS
  );

  modport slave (
    input  HREADYS, sel_dec, decode_addr_dec, trans_dec,
           active_dec_i, readyout_dec_i, resp_dec_i, rdata_dec_i, ruser_dec_i,
    output sel_dec_o, active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS
  );
endinterface
`default_nettype wire

// File: rtl/cmsdk_ahb_param_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : cmsdk_ahb_param_decoder
// Brief   : Parametrised BASE/MASK input-port decoder with built-in two-cycle
//           ERROR default slave. Optional unmapped-access log: DECODER_ERR_LOG_EN.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module cmsdk_ahb_param_decoder #(
  parameter int               NUM_PORTS   = 2,
  parameter int               DATA_W      = 32,
  parameter int               USER_W      = 32,
  parameter logic [8*22-1:0]  REGION_BASE = {8{22'h000000}},
  parameter logic [8*22-1:0]  REGION_MASK = {8{22'h3fffff}}
) (
  input  logic                              HCLK,
  input  logic                              HRESET,
  cmsdk_ahb_param_decoder_if.slave          bus
`ifdef DECODER_ERR_LOG_EN
  ,
  input  logic                              err_clr,
  output logic                              err_valid,
  output logic [21:0]                       err_addr,
  output logic [7:0]                        err_count
`endif
);

  localparam int             PW         = $clog2(NUM_PORTS + 1);
  localparam logic [PW-1:0]  DS_IDX     = PW'(NUM_PORTS);
  localparam logic [1:0]     TRANS_IDLE = 2'b00;
  localparam logic [1:0]     RESP_OKAY  = 2'b00;
  localparam logic [1:0]     RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  logic [PW-1:0]  w_hit_port;
  logic [PW-1:0]  w_addr_port;
  logic [PW-1:0]  r_data_port;
  logic           w_sel_dft;
  logic           w_ds_accept;
  ds_state_t      r_ds_state;
  logic           r_ds_ready;
  logic [1:0]     r_ds_resp;

  // Descending scan so the lowest matching region wins on overlap.
  always_comb begin
    w_hit_port = DS_IDX;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((bus.decode_addr_dec & REGION_MASK[i*22 +: 22]) ==
          (REGION_BASE[i*22 +: 22] & REGION_MASK[i*22 +: 22])) begin
        w_hit_port = PW'(i);
      end
    end
  end

  // An IDLE keeps pointing at the port still completing its data phase.
  always_comb begin
    if ((bus.trans_dec == TRANS_IDLE) && (r_data_port < DS_IDX)) begin
      w_addr_port = r_data_port;
    end else begin
      w_addr_port = w_hit_port;
    end
  end

  assign w_sel_dft   = bus.sel_dec & (w_addr_port == DS_IDX);
  assign w_ds_accept = w_sel_dft & bus.HREADYS & bus.trans_dec[1];

  always_comb begin
    bus.sel_dec_o  = '0;
    bus.active_dec = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_addr_port == PW'(i)) begin
        bus.sel_dec_o[i] = bus.sel_dec;
        bus.active_dec   = bus.active_dec_i[i];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_data_port <= DS_IDX;
    end else if (bus.HREADYS) begin
      r_data_port <= w_addr_port;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_ds_state <= DS_IDLE;
      r_ds_ready <= 1'b1;
      r_ds_resp  <= RESP_OKAY;
    end else begin
      case (r_ds_state)
        DS_IDLE: begin
          if (w_ds_accept) begin
            r_ds_state <= DS_ERR1;
            r_ds_ready <= 1'b0;
            r_ds_resp  <= RESP_ERROR;
          end else begin
            r_ds_state <= DS_IDLE;
            r_ds_ready <= 1'b1;
            r_ds_resp  <= RESP_OKAY;
          end
        end
        DS_ERR1: begin
          r_ds_state <= DS_ERR2;
          r_ds_ready <= 1'b1;
          r_ds_resp  <= RESP_ERROR;
        end
        DS_ERR2: begin
          // A pipelined unmapped access restarts the error without an idle gap.
          if (w_ds_accept) begin
            r_ds_state <= DS_ERR1;
            r_ds_ready <= 1'b0;
            r_ds_resp  <= RESP_ERROR;
          end else begin
            r_ds_state <= DS_IDLE;
            r_ds_ready <= 1'b1;
            r_ds_resp  <= RESP_OKAY;
          end
        end
        default: begin
          r_ds_state <= DS_IDLE;
          r_ds_ready <= 1'b1;
          r_ds_resp  <= RESP_OKAY;
        end
      endcase
    end
  end

  always_comb begin
    bus.HREADYOUTS = r_ds_ready;
    bus.HRESPS     = r_ds_resp;
    bus.HRDATAS    = '0;
    bus.HRUSERS    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_data_port == PW'(i)) begin
        bus.HREADYOUTS = bus.readyout_dec_i[i];
        bus.HRESPS     = bus.resp_dec_i[2*i +: 2];
        bus.HRDATAS    = bus.rdata_dec_i[DATA_W*i +: DATA_W];
        bus.HRUSERS    = bus.ruser_dec_i[USER_W*i +: USER_W];
      end
    end
  end

`ifdef DECODER_ERR_LOG_EN
  logic         r_err_valid;
  logic [21:0]  r_err_addr;
  logic [7:0]   r_err_count;

  // A capture coinciding with a clear is kept as the first logged access.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_count <= '0;
    end else if (err_clr) begin
      r_err_valid <= w_ds_accept;
      r_err_addr  <= w_ds_accept ? bus.decode_addr_dec : 22'd0;
      r_err_count <= {7'd0, w_ds_accept};
    end else if (w_ds_accept) begin
      if (r_err_count != 8'hff) begin
        r_err_count <= r_err_count + 8'd1;
      end
      if (!r_err_valid) begin
        r_err_valid <= 1'b1;
        r_err_addr  <= bus.decode_addr_dec;
      end
    end
  end

  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;
  assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmsdk_ahb_param_decoder.sv
`default_nettype none
// Directed bench for cmsdk_ahb_param_decoder: address-phase selects are checked
// directly, data-phase returns go through an expected-value queue.
module tb_cmsdk_ahb_param_decoder;

  localparam int NP = 2;
  localparam int DW = 32;
  localparam int UW = 32;
  localparam logic [175:0] BASE    = {{6{22'h000000}}, 22'h100000, 22'h080000};
  localparam logic [175:0] MASK    = {{6{22'h3fffff}}, 22'h3c0000, 22'h380000};
  localparam logic [175:0] OV_BASE = {{6{22'h000000}}, 22'h080000, 22'h080000};
  localparam logic [1:0]   IDLE    = 2'b00;
  localparam logic [1:0]   NONSEQ  = 2'b10;
  localparam logic [21:0]  UNMAP   = 22'h240000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmsdk_ahb_param_decoder_if #(.NUM_PORTS(NP), .DATA_W(DW), .USER_W(UW)) bus ();
  cmsdk_ahb_param_decoder_if #(.NUM_PORTS(NP), .DATA_W(DW), .USER_W(UW)) ovb ();

  assign bus.HREADYS = bus.HREADYOUTS;

`ifdef DECODER_ERR_LOG_EN
  logic        err_clr;
  logic        err_valid;
  logic [21:0] err_addr;
  logic [7:0]  err_count;
  logic        ov_err_valid;
  logic [21:0] ov_err_addr;
  logic [7:0]  ov_err_count;
`endif

  cmsdk_ahb_param_decoder #(
    .NUM_PORTS(NP), .DATA_W(DW), .USER_W(UW), .REGION_BASE(BASE), .REGION_MASK(MASK)
  ) dut (
    .HCLK(clk), .HRESET(rst), .bus(bus)
`ifdef DECODER_ERR_LOG_EN
    , .err_clr(err_clr), .err_valid(err_valid), .err_addr(err_addr), .err_count(err_count)
`endif
  );

  cmsdk_ahb_param_decoder #(
    .NUM_PORTS(NP), .DATA_W(DW), .USER_W(UW), .REGION_BASE(OV_BASE), .REGION_MASK(MASK)
  ) dut_ov (
    .HCLK(clk), .HRESET(rst), .bus(ovb)
`ifdef DECODER_ERR_LOG_EN
    , .err_clr(1'b0), .err_valid(ov_err_valid), .err_addr(ov_err_addr), .err_count(ov_err_count)
`endif
  );

  typedef struct packed {
    logic        ready;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [31:0] user;
  } dp_t;

  dp_t   exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_dp(input string tag, input logic r, input logic [1:0] rs,
                           input logic [31:0] d, input logic [31:0] u);
    dp_t e;
    e.ready = r;
    e.resp  = rs;
    e.data  = d;
    e.user  = u;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic tick();
    dp_t   e;
    dp_t   o;
    string t;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = {bus.HREADYOUTS, bus.HRESPS, bus.HRDATAS, bus.HRUSERS};
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", t, o, e);
      end
    end
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr, input logic [21:0] a);
    bus.sel_dec         = sel;
    bus.trans_dec       = tr;
    bus.decode_addr_dec = a;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.sel_dec = 1'b0; bus.trans_dec = IDLE; bus.decode_addr_dec = '0;
    bus.active_dec_i   = 2'b10;
    bus.readyout_dec_i = 2'b11;
    bus.resp_dec_i     = 4'b0000;
    bus.rdata_dec_i    = {32'hCAFEF00D, 32'hDEADBEEF};
    bus.ruser_dec_i    = {32'h22222222, 32'h11111111};
    ovb.HREADYS = 1'b1; ovb.sel_dec = 1'b1; ovb.trans_dec = NONSEQ; ovb.decode_addr_dec = '0;
    ovb.active_dec_i = '0; ovb.readyout_dec_i = 2'b11; ovb.resp_dec_i = '0;
    ovb.rdata_dec_i = '0; ovb.ruser_dec_i = '0;
`ifdef DECODER_ERR_LOG_EN
    err_clr = 1'b0;
`endif
    tick(); tick();
    chk("rst_ready", 32'(bus.HREADYOUTS), 32'd1);
    chk("rst_resp",  32'(bus.HRESPS), 32'd0);
    chk("rst_rdata", bus.HRDATAS, 32'd0);
    chk("rst_ruser", bus.HRUSERS, 32'd0);
    chk("rst_sel",   32'(bus.sel_dec_o), 32'd0);
`ifdef DECODER_ERR_LOG_EN
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
`endif

    rst = 1'b0;
    drive(1'b1, NONSEQ, 22'h080000);
    chk("p0_sel", 32'(bus.sel_dec_o), 32'd1);
    chk("p0_active", 32'(bus.active_dec), 32'd0);
    expect_dp("p0_read", 1'b1, 2'b00, 32'hDEADBEEF, 32'h11111111);
    tick();

    drive(1'b1, NONSEQ, UNMAP);
    chk("ds_sel", 32'(bus.sel_dec_o), 32'd0);
    chk("ds_active", 32'(bus.active_dec), 32'd1);
    expect_dp("ds_err1", 1'b0, 2'b01, 32'd0, 32'd0);
    tick();
    drive(1'b0, IDLE, 22'd0);
    expect_dp("ds_err2", 1'b1, 2'b01, 32'd0, 32'd0);
    tick();
    drive(1'b1, IDLE, UNMAP);
    expect_dp("ds_idle_okay", 1'b1, 2'b00, 32'd0, 32'd0);
    tick();
    drive(1'b1, 2'b01, UNMAP);
    expect_dp("ds_busy_okay", 1'b1, 2'b00, 32'd0, 32'd0);
    tick();

    drive(1'b1, NONSEQ, UNMAP);
    expect_dp("b2b_a_err1", 1'b0, 2'b01, 32'd0, 32'd0);
    tick();
    drive(1'b1, NONSEQ, 22'h250000);
    expect_dp("b2b_a_err2", 1'b1, 2'b01, 32'd0, 32'd0);
    tick();
    drive(1'b1, NONSEQ, 22'h250000);
    expect_dp("b2b_b_err1", 1'b0, 2'b01, 32'd0, 32'd0);
    tick();
    drive(1'b0, IDLE, 22'd0);
    expect_dp("b2b_b_err2", 1'b1, 2'b01, 32'd0, 32'd0);
    tick();
    drive(1'b0, IDLE, 22'd0);
    expect_dp("b2b_idle", 1'b1, 2'b00, 32'd0, 32'd0);
    tick();

    bus.readyout_dec_i = 2'b01;
    drive(1'b1, NONSEQ, 22'h100000);
    chk("p1_sel", 32'(bus.sel_dec_o), 32'd2);
    chk("p1_active", 32'(bus.active_dec), 32'd1);
    expect_dp("p1_wait1", 1'b0, 2'b00, 32'hCAFEF00D, 32'h22222222);
    tick();
    drive(1'b1, IDLE, UNMAP);
    chk("hold_sel1", 32'(bus.sel_dec_o), 32'd2);
    expect_dp("p1_wait2", 1'b0, 2'b00, 32'hCAFEF00D, 32'h22222222);
    tick();
    drive(1'b1, IDLE, UNMAP);
    chk("hold_sel2", 32'(bus.sel_dec_o), 32'd2);
    expect_dp("p1_wait3", 1'b0, 2'b00, 32'hCAFEF00D, 32'h22222222);
    tick();
    bus.readyout_dec_i = 2'b11;
    drive(1'b1, IDLE, UNMAP);
    chk("hold_sel3", 32'(bus.sel_dec_o), 32'd2);
    expect_dp("p1_done", 1'b1, 2'b00, 32'hCAFEF00D, 32'h22222222);
    tick();
    bus.resp_dec_i = 4'b0100;
    drive(1'b0, IDLE, 22'd0);
    expect_dp("p1_resp", 1'b1, 2'b01, 32'hCAFEF00D, 32'h22222222);
    tick();
    bus.resp_dec_i = 4'b0000;

    drive(1'b1, NONSEQ, UNMAP);
    expect_dp("pre_rst_err1", 1'b0, 2'b01, 32'd0, 32'd0);
    tick();
    rst = 1'b1;
    drive(1'b0, IDLE, 22'd0);
    expect_dp("rst_in_err1", 1'b1, 2'b00, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, IDLE, 22'd0);
    expect_dp("post_rst_idle", 1'b1, 2'b00, 32'd0, 32'd0);
    tick();

    ovb.decode_addr_dec = 22'h080000; #1;
    chk("ov_2000", 32'(ovb.sel_dec_o), 32'd1);
    ovb.decode_addr_dec = 22'h090000; #1;
    chk("ov_2400", 32'(ovb.sel_dec_o), 32'd1);
    ovb.decode_addr_dec = 22'h0c0000; #1;
    chk("ov_3000", 32'(ovb.sel_dec_o), 32'd1);
    ovb.decode_addr_dec = 22'h100000; #1;
    chk("ov_4000", 32'(ovb.sel_dec_o), 32'd0);

`ifdef DECODER_ERR_LOG_EN
    chk("log_clean", 32'(err_valid), 32'd0);
    drive(1'b1, NONSEQ, 22'h280001);
    expect_dp("log_a_err1", 1'b0, 2'b01, 32'd0, 32'd0);
    tick();
    drive(1'b1, NONSEQ, 22'h2c0000);
    expect_dp("log_a_err2", 1'b1, 2'b01, 32'd0, 32'd0);
    tick();
    drive(1'b1, NONSEQ, 22'h2c0000);
    expect_dp("log_b_err1", 1'b0, 2'b01, 32'd0, 32'd0);
    tick();
    drive(1'b1, NONSEQ, 22'h300000);
    expect_dp("log_b_err2", 1'b1, 2'b01, 32'd0, 32'd0);
    tick();
    drive(1'b1, NONSEQ, 22'h300000);
    expect_dp("log_c_err1", 1'b0, 2'b01, 32'd0, 32'd0);
    tick();
    drive(1'b0, IDLE, 22'd0);
    expect_dp("log_c_err2", 1'b1, 2'b01, 32'd0, 32'd0);
    tick();
    chk("log_valid", 32'(err_valid), 32'd1);
    chk("log_addr",  32'(err_addr), 32'h280001);
    chk("log_count", 32'(err_count), 32'd3);
    err_clr = 1'b1;
    drive(1'b0, IDLE, 22'd0);
    expect_dp("log_clr_idle", 1'b1, 2'b00, 32'd0, 32'd0);
    tick();
    err_clr = 1'b0;
    chk("clr_valid", 32'(err_valid), 32'd0);
    chk("clr_addr",  32'(err_addr), 32'd0);
    chk("clr_count", 32'(err_count), 32'd0);
    err_clr = 1'b1;
    drive(1'b1, NONSEQ, 22'h340000);
    expect_dp("log_d_err1", 1'b0, 2'b01, 32'd0, 32'd0);
    tick();
    err_clr = 1'b0;
    chk("clrcap_valid", 32'(err_valid), 32'd1);
    chk("clrcap_addr",  32'(err_addr), 32'h340000);
    chk("clrcap_count", 32'(err_count), 32'd1);
    drive(1'b0, IDLE, 22'd0);
    expect_dp("log_d_err2", 1'b1, 2'b01, 32'd0, 32'd0);
    tick();
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
